instr_trace_monitor: RTL

- Synthesizable retirement-trace and instruction-profile block for the pipelined MIPS CPU.
- Sits beside the CPU and taps the write-back stage.
- Classifies each retired instruction into one of 17 classes and keeps a saturating count per class.
- Logs {class, PC, write-back data} into a circular trace buffer, with a PC-match trigger that freezes the buffer a fixed number of instructions after the match.

---
 rtl/instr_trace_monitor.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_trace_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_trace_monitor: classifies retired MIPS instructions, keeps         |
// | saturating per-class counts and a PC-triggered circular trace buffer.    |
// | Optional macro TRACE_WD_EN adds per-entry write-back data storage.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_trace_monitor #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     arm,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     ret_valid,
  input  logic [PC_W-1:0]          ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic [31:0]              ret_wd,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [4:0]               rd_class,
  output logic [PC_W-1:0]          rd_pc,
  output logic [31:0]              rd_wd,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state,
  input  logic [4:0]               cnt_sel,
  output logic [CNT_W-1:0]         cnt_val
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NCLS = 17;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_POST   = 2'd2;
  localparam logic [1:0] ST_FROZEN = 2'd3;

  localparam logic [4:0] CLS_ADD   = 5'd0;
  localparam logic [4:0] CLS_SUB   = 5'd1;
  localparam logic [4:0] CLS_AND   = 5'd2;
  localparam logic [4:0] CLS_OR    = 5'd3;
  localparam logic [4:0] CLS_SLL   = 5'd4;
  localparam logic [4:0] CLS_NOP   = 5'd5;
  localparam logic [4:0] CLS_SLT   = 5'd6;
  localparam logic [4:0] CLS_MULTU = 5'd7;
  localparam logic [4:0] CLS_MFHI  = 5'd8;
  localparam logic [4:0] CLS_MFLO  = 5'd9;
  localparam logic [4:0] CLS_JR    = 5'd10;
  localparam logic [4:0] CLS_ANDI  = 5'd11;
  localparam logic [4:0] CLS_LW    = 5'd12;
  localparam logic [4:0] CLS_SW    = 5'd13;
  localparam logic [4:0] CLS_BEQ   = 5'd14;
  localparam logic [4:0] CLS_J     = 5'd15;
  localparam logic [4:0] CLS_OTHER = 5'd16;

  localparam logic [AW:0]      LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    POST_INIT  = AW'(POST_TRIG);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [AW-1:0]    rem_q;
  logic [AW-1:0]    rem_d;
  logic [AW-1:0]    wrptr;
  logic [AW:0]      level_q;
  logic [4:0]       cls;
  logic             capture;
  logic             pc_match;
  logic [AW-1:0]    rd_addr;
  logic             rd_hit;
  logic [CNT_W-1:0] cnt_q [0:NCLS-1];
  logic [4:0]       cls_mem [0:DEPTH-1];
  logic [PC_W-1:0]  pc_mem [0:DEPTH-1];

  // Instruction classification
  always_comb begin
    cls = CLS_OTHER;
    if (ret_instr[31:26] == 6'd0) begin
      case (ret_instr[5:0])
        6'd32:   cls = CLS_ADD;
        6'd34:   cls = CLS_SUB;
        6'd36:   cls = CLS_AND;
        6'd37:   cls = CLS_OR;
        6'd42:   cls = CLS_SLT;
        6'd25:   cls = CLS_MULTU;
        6'd16:   cls = CLS_MFHI;
        6'd18:   cls = CLS_MFLO;
        6'd8:    cls = CLS_JR;
        6'd0:    cls = (ret_instr == 32'h0) ? CLS_NOP : CLS_SLL;
        default: cls = CLS_OTHER;
      endcase
    end else begin
      case (ret_instr[31:26])
        6'd12:   cls = CLS_ANDI;
        6'd35:   cls = CLS_LW;
        6'd43:   cls = CLS_SW;
        6'd4:    cls = CLS_BEQ;
        6'd2:    cls = CLS_J;
        default: cls = CLS_OTHER;
      endcase
    end
  end

  assign capture  = ret_valid && (state_q != ST_FROZEN) && !clr;
  assign pc_match = (ret_pc == trig_pc);

  // Trigger state machine: register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Trigger state machine: next state (arm in ARMED/POST falls through unhandled)
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (clr) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (capture && pc_match) begin
            if (POST_TRIG == 0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_POST;
              rem_d   = POST_INIT;
            end
          end
        end
        ST_POST: begin
          if (capture) begin
            rem_d = rem_q - AW'(1);
            if (rem_q == AW'(1)) state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          if (arm) state_d = ST_ARMED;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Trigger state machine: outputs
  always_comb begin
    state = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrptr   <= '0;
      level_q <= '0;
    end else if (clr) begin
      wrptr   <= '0;
      level_q <= '0;
    end else if (capture) begin
      wrptr <= wrptr + AW'(1);
      if (level_q != LEVEL_FULL) level_q <= level_q + (AW+1)'(1);
    end
  end

  assign level = level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
    end else if (capture && (cnt_q[cls] != CNT_MAX)) begin
      cnt_q[cls] <= cnt_q[cls] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_val = '0;
    if (cnt_sel <= CLS_OTHER) cnt_val = cnt_q[cnt_sel];
  end

  // Trace storage carries no reset; validity is tracked by level alone
  always_ff @(posedge clk) begin
    if (capture) begin
      cls_mem[wrptr] <= cls;
      pc_mem[wrptr]  <= ret_pc;
    end
  end

  // Oldest entry sits level slots behind the write pointer
  assign rd_addr = wrptr - level_q[AW-1:0] + rd_idx;
  assign rd_hit  = ({1'b0, rd_idx} < level_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_class <= '0;
      rd_pc    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en && rd_hit) begin
        rd_class <= cls_mem[rd_addr];
        rd_pc    <= pc_mem[rd_addr];
      end else begin
        rd_class <= '0;
        rd_pc    <= '0;
      end
    end
  end

`ifdef TRACE_WD_EN
  logic [31:0] wd_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (capture) wd_mem[wrptr] <= ret_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_wd <= '0;
    end else if (rd_en && rd_hit) begin
      rd_wd <= wd_mem[rd_addr];
    end else begin
      rd_wd <= '0;
    end
  end
`else
  logic [31:0] unused_wd;
  assign unused_wd = ret_wd;
  assign rd_wd     = '0;
`endif

endmodule
`default_nettype wire
